video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter PIX_W, default 8: bits per colour channel; pixel word is 3*PIX_W bits, laid out {R,G,B}.
REQ-002 SHALL have parameter H_ACTIVE, default 640: pixels per line; must be a multiple of 8.
REQ-003 SHALL have parameter V_ACTIVE, default 480: lines per frame.
REQ-004 SHALL have parameter ADDR_W, default 20: address width; must be >= clog2(H_ACTIVE*V_ACTIVE).
REQ-005 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port en, input, 1: start/continue frame generation.
REQ-008 SHALL have port mode, input, 2: 0 ramp, 1 colour bars, 2 checkerboard, 3 solid.
REQ-009 SHALL have port solid, input, 3*PIX_W: colour used in mode 3.
REQ-010 SHALL have port m_ready, input, 1: downstream accepts pixel.
REQ-011 SHALL have port m_valid, output, 1: pixel presented.
REQ-012 SHALL have port m_data, output, 3*PIX_W: pixel value.
REQ-013 SHALL have port m_addr, output, ADDR_W: linear frame-buffer address y*H_ACTIVE+x.
REQ-014 SHALL have port m_sof, output, 1: high with pixel (0,0).
REQ-015 SHALL have port m_eol, output, 1: high with pixel x=H_ACTIVE-1.
REQ-016 SHALL have port frame_cnt, output, 16: completed frames, wraps modulo 2^16.

Function
REQ-017 SHALL implement FSM IDLE/ACTIVE; IDLE: m_valid=0; IDLE->ACTIVE when en=1; ACTIVE->IDLE after last pixel of frame transfers with en=0.
REQ-018 SHALL present pixel (0,0) with m_valid=1 the cycle after en is sampled high in IDLE.
REQ-019 SHALL count a transfer only on cycles with m_valid=1 and m_ready=1; x, y and m_addr advance one pixel per transfer.
REQ-020 SHALL hold m_data, m_addr, m_sof, m_eol stable while m_valid=1 and m_ready=0; m_valid never drops without a transfer, except on rst.
REQ-021 SHALL wrap x to 0 and increment y after x=H_ACTIVE-1; after pixel (H_ACTIVE-1,V_ACTIVE-1) wrap x, y, m_addr to 0 and increment frame_cnt.
REQ-022 SHALL, with en=1 at end of frame, present pixel (0,0) of the next frame the cycle after the last transfer, with no bubble.
REQ-023 SHALL, when en drops mid-frame, finish the current frame, then enter IDLE.
REQ-024 SHALL latch mode and solid when pixel (0,0) is first presented; mid-frame changes take effect next frame.
REQ-025 Mode 0 SHALL output a free-running transfer counter, width 3*PIX_W, wrapping modulo 2^(3*PIX_W), cleared only by rst, not at frame boundaries.
REQ-026 Mode 1 SHALL output 8 bars, bar b = x/(H_ACTIVE/8), code c=7-b; R all-ones if c[2], G if c[1], B if c[0], else zero.
REQ-027 Mode 2 SHALL output all-ones when x[3]^y[3]=1, else all-zeros (8x8 squares).
REQ-028 Mode 3 SHALL output latched solid.

Reset
REQ-029 SHALL, on rst, force IDLE, m_valid=0, m_data=0, m_addr=0, m_sof=0, m_eol=0, frame_cnt=0, x=y=0, ramp counter=0, latched mode=0, latched solid=0, from the next edge, including mid-frame.

Verification (H_ACTIVE=16, V_ACTIVE=4, ADDR_W=6, PIX_W=8)
REQ-030 SHALL cover: mode 0, m_ready=1, en=1 -> 64 pixels data 0x000000..0x00003F, addr 0..63, m_sof on pixel 0, m_eol on pixels 15/31/47/63, frame_cnt=1, next frame data 0x000040 addr 0.
REQ-031 SHALL cover: m_ready toggling 1010... -> each value held while m_ready=0, no pixel skipped or repeated, 64 transfers per frame.
REQ-032 SHALL cover: mode 1 -> x=0,1 0xFFFFFF; x=2 0xFFFF00; x=4 0xFF00FF; x=14,15 0x000000.
REQ-033 SHALL cover: mode 0->2 switched at pixel 20 -> frame 0 stays ramp; frame 1 (0,0)=0x000000, (8,0)=0xFFFFFF.
REQ-034 SHALL cover: en=0 after pixel 10 -> pixels through 63 delivered, then m_valid=0, frame_cnt=1.
REQ-035 SHALL cover: rst at pixel 30 -> next cycle m_valid=0, frame_cnt=0; after release with en=1, data 0x000000, addr 0, m_sof=1.

Source files
------------

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: streams ramp, colour-bar, checkerboard or solid test frames with valid/ready handshake.
module video_pattern_gen #(
  parameter int PIX_W = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [3*PIX_W-1:0]   solid,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [3*PIX_W-1:0]   m_data,
  output logic [ADDR_W-1:0]    m_addr,
  output logic                 m_sof,
  output logic                 m_eol,
  output logic [15:0]          frame_cnt
);
  localparam int DW = 3 * PIX_W;
  localparam int XW = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
  localparam int YW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [DW-1:0] ramp, ramp_n, lsolid;
  logic [1:0] lmode;
  logic xfer, last_x, last_y, frame_end;
  assign xfer = m_valid & m_ready;
  assign last_x = x == XW'(H_ACTIVE - 1);
  assign last_y = y == YW'(V_ACTIVE - 1);
  assign frame_end = last_x & last_y;
  assign nx = last_x ? '0 : x + 1'b1;
  assign ny = last_x ? (last_y ? '0 : y + 1'b1) : y;
  assign ramp_n = ramp + 1'b1;
  // Pixel colour for coordinate (px,py); r is the transfer count the pixel carries in ramp mode.
  function automatic logic [DW-1:0] pix(input logic [1:0] md, input logic [DW-1:0] sd,
                                        input logic [XW-1:0] px, input logic [YW-1:0] py,
                                        input logic [DW-1:0] r);
    logic [2:0] c;
    logic chk;
    c = 3'(7 - int'(px) / (H_ACTIVE / 8));
    chk = ((32'(px) ^ 32'(py)) & 32'd8) != 0;
    return md == 2'd0 ? r :
           md == 2'd1 ? {{PIX_W{c[2]}}, {PIX_W{c[1]}}, {PIX_W{c[0]}}} :
           md == 2'd2 ? {DW{chk}} : sd;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_valid <= 1'b0;
      m_data <= '0;
      m_addr <= '0;
      m_sof <= 1'b0;
      m_eol <= 1'b0;
      frame_cnt <= '0;
      x <= '0;
      y <= '0;
      ramp <= '0;
      lmode <= '0;
      lsolid <= '0;
    end else if (state == IDLE) begin
      if (en) begin
        state <= ACTIVE;
        m_valid <= 1'b1;
        x <= '0;
        y <= '0;
        m_addr <= '0;
        lmode <= mode;
        lsolid <= solid;
        m_data <= pix(mode, solid, '0, '0, ramp);
        m_sof <= 1'b1;
        m_eol <= 1'b0;
      end
    end else if (xfer) begin
      ramp <= ramp_n;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
        x <= '0;
        y <= '0;
        m_addr <= '0;
        // Back-to-back frames relatch mode/solid as pixel (0,0) goes out.
        if (en) begin
          lmode <= mode;
          lsolid <= solid;
          m_data <= pix(mode, solid, '0, '0, ramp_n);
          m_sof <= 1'b1;
          m_eol <= 1'b0;
        end else begin
          state <= IDLE;
          m_valid <= 1'b0;
          m_sof <= 1'b0;
          m_eol <= 1'b0;
        end
      end else begin
        x <= nx;
        y <= ny;
        m_addr <= m_addr + 1'b1;
        m_data <= pix(lmode, lsolid, nx, ny, ramp_n);
        m_sof <= 1'b0;
        m_eol <= nx == XW'(H_ACTIVE - 1);
      end
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed checks of the pattern generator on a 16x4 frame.
module tb_video_pattern_gen;
  logic clk = 0, rst = 1, en = 0, m_ready = 0;
  logic [1:0] mode = 0;
  logic [23:0] solid = 0, m_data;
  logic m_valid, m_sof, m_eol;
  logic [5:0] m_addr;
  logic [15:0] frame_cnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  video_pattern_gen #(.PIX_W(8), .H_ACTIVE(16), .V_ACTIVE(4), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid(solid), .m_ready(m_ready),
    .m_valid(m_valid), .m_data(m_data), .m_addr(m_addr), .m_sof(m_sof), .m_eol(m_eol),
    .frame_cnt(frame_cnt));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1; en = 0; m_ready = 0; mode = 0; solid = 0;
    step();
    rst = 0;
  endtask
  task automatic test_reset;
    do_reset();
    tests++;
    if ({m_valid, m_data, m_addr, m_sof, m_eol, frame_cnt} !== 49'd0) begin
      fails++;
      $display("FAIL reset: valid=%0b data=%h addr=%0d sof=%0b eol=%0b fc=%0d, required all zero",
               m_valid, m_data, m_addr, m_sof, m_eol, frame_cnt);
    end
  endtask
  task automatic test_ramp_frame;
    logic [32:0] exp_v;
    do_reset();
    en = 1; m_ready = 1;
    step();
    for (int i = 0; i < 64; i++) begin
      exp_v = {1'b1, 24'(i), 6'(i), i == 0, i % 16 == 15};
      tests++;
      if ({m_valid, m_data, m_addr, m_sof, m_eol} !== exp_v) begin
        fails++;
        $display("FAIL ramp px%0d: got v=%0b d=%h a=%0d sof=%0b eol=%0b, required %h",
                 i, m_valid, m_data, m_addr, m_sof, m_eol, exp_v);
      end
      step();
    end
    tests++;
    if ({m_valid, m_data, m_addr, m_sof, frame_cnt} !== {1'b1, 24'h40, 6'd0, 1'b1, 16'd1}) begin
      fails++;
      $display("FAIL ramp next frame: v=%0b d=%h a=%0d sof=%0b fc=%0d, required 1 000040 0 1 1",
               m_valid, m_data, m_addr, m_sof, frame_cnt);
    end
  endtask
  task automatic test_backpressure;
    int cnt = 0;
    do_reset();
    en = 1;
    step();
    for (int c = 0; c < 200 && cnt < 64; c++) begin
      m_ready = c % 2 == 0;
      tests++;
      if ({m_valid, m_data, m_addr} !== {1'b1, 24'(cnt), 6'(cnt)}) begin
        fails++;
        $display("FAIL backpressure cyc%0d: v=%0b d=%h a=%0d, required 1 %h %0d",
                 c, m_valid, m_data, m_addr, 24'(cnt), cnt);
      end
      if (m_ready) cnt++;
      step();
    end
    tests++;
    if (cnt !== 64 || frame_cnt !== 16'd1) begin
      fails++;
      $display("FAIL backpressure total: transfers=%0d fc=%0d, required 64 1", cnt, frame_cnt);
    end
  endtask
  task automatic test_bars;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                              24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};
    do_reset();
    mode = 1; en = 1; m_ready = 1;
    step();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (m_data !== bars[i / 2]) begin
        fails++;
        $display("FAIL bars x%0d: got %h, required %h", i, m_data, bars[i / 2]);
      end
      step();
    end
  endtask
  task automatic test_mode_switch;
    do_reset();
    mode = 0; en = 1; m_ready = 1;
    step();
    for (int i = 0; i < 64; i++) begin
      if (i == 20) mode = 2;
      tests++;
      if (m_data !== 24'(i)) begin
        fails++;
        $display("FAIL switch frame0 px%0d: got %h, required %h", i, m_data, 24'(i));
      end
      step();
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || i == 8) begin
        tests++;
        if (m_data !== (i == 8 ? 24'hFFFFFF : 24'h0)) begin
          fails++;
          $display("FAIL switch frame1 x%0d: got %h, required %h", i, m_data,
                   i == 8 ? 24'hFFFFFF : 24'h0);
        end
      end
      step();
    end
  endtask
  task automatic test_en_drop;
    do_reset();
    en = 1; m_ready = 1;
    step();
    for (int i = 0; i < 64; i++) begin
      if (i == 10) en = 0;
      tests++;
      if ({m_valid, m_data} !== {1'b1, 24'(i)}) begin
        fails++;
        $display("FAIL en_drop px%0d: v=%0b d=%h, required 1 %h", i, m_valid, m_data, 24'(i));
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (m_valid !== 1'b0 || frame_cnt !== 16'd1) begin
        fails++;
        $display("FAIL en_drop idle%0d: v=%0b fc=%0d, required 0 1", i, m_valid, frame_cnt);
      end
      step();
    end
  endtask
  task automatic test_rst_mid;
    do_reset();
    en = 1; m_ready = 1;
    step();
    for (int i = 0; i < 30; i++) step();
    tests++;
    if (m_data !== 24'd30) begin
      fails++;
      $display("FAIL rst_mid pre: got %h, required 00001e", m_data);
    end
    rst = 1;
    step();
    tests++;
    if ({m_valid, frame_cnt, m_data, m_addr} !== 47'd0) begin
      fails++;
      $display("FAIL rst_mid during: v=%0b fc=%0d d=%h a=%0d, required all zero",
               m_valid, frame_cnt, m_data, m_addr);
    end
    rst = 0;
    step();
    tests++;
    if ({m_valid, m_data, m_addr, m_sof} !== {1'b1, 24'h0, 6'd0, 1'b1}) begin
      fails++;
      $display("FAIL rst_mid restart: v=%0b d=%h a=%0d sof=%0b, required 1 000000 0 1",
               m_valid, m_data, m_addr, m_sof);
    end
  endtask
  initial begin
    test_reset();
    test_ramp_frame();
    test_backpressure();
    test_bars();
    test_mode_switch();
    test_en_drop();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
